// File: rtl/sl_sram_banked_pkg.sv
// ----------------------------------------------------------------------------
// sl_sram_pkg : shared types, macro tie-offs and build checks for sl_sram_banked
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sl_sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } init_state_e;

   localparam logic [2:0] c_macro_ema   = 3'b010;
   localparam logic [1:0] c_macro_emaw  = 2'b00;
   localparam logic       c_macro_ret1n = 1'b1;

   // Only the 8KB (13) and 16KB (14) macros exist in the library.
   function automatic bit bank_aw_legal(input int bank_aw);
      return (bank_aw == 13) || (bank_aw == 14);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sl_sram_banked_if.sv
// ----------------------------------------------------------------------------
// sl_sram_banked_if : host access port of the banked SRAM (CS/WREN/ADDR/WDATA)
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sl_sram_banked_if #(
   parameter int AW = 16
) ();
   logic [AW-1:2] ADDR;
   logic [31:0]   WDATA;
   logic [3:0]    WREN;
   logic          CS;
   logic [31:0]   RDATA;
   logic          READY;
   logic          INIT_REQ;
   logic          INIT_BUSY;
   logic          INIT_DONE;

   modport master (
      output ADDR, WDATA, WREN, CS, INIT_REQ,
      input  RDATA, READY, INIT_BUSY, INIT_DONE
   );

   modport slave (
      input  ADDR, WDATA, WREN, CS, INIT_REQ,
      output RDATA, READY, INIT_BUSY, INIT_DONE
   );
endinterface

`default_nettype wire

// File: rtl/sl_sram_banked_init_ctrl.sv
// ----------------------------------------------------------------------------
// sl_sram_init_ctrl : zero-clear sequencer, walks every word index once per run
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sl_sram_init_ctrl
   import sl_sram_pkg::*;
#(
   parameter int IDX_W = 12
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             i_init_req,
   output logic             o_clr_en,
   output logic [IDX_W-1:0] o_clr_idx,
   output logic             o_ready,
   output logic             o_init_busy,
   output logic             o_init_done
);
   localparam logic [IDX_W-1:0] c_last_idx = '1;

   init_state_e      state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             clr_en_q, clr_en_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (i_init_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == c_last_idx) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // Outputs are decoded from the next state so they are flop-driven.
      clr_en_d = (state_d == ST_CLEAR);
      ready_d  = (state_d == ST_IDLE);
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q  <= ST_CLEAR;
         cnt_q    <= '0;
         clr_en_q <= 1'b1;
         ready_q  <= 1'b0;
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         clr_en_q <= clr_en_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign o_clr_en    = clr_en_q;
   assign o_clr_idx   = cnt_q;
   assign o_ready     = ready_q;
   assign o_init_busy = busy_q;
   assign o_init_done = done_q;
endmodule

`default_nettype wire

// File: rtl/sl_sram_banked_macros.sv
// ----------------------------------------------------------------------------
// rf_16k / rf_08k : behavioural single-port 32-bit register-file macros
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sl_sram_rf_model #(
   parameter int IDX_W = 12
) (
   input  logic             CLK,
   input  logic             CEN,
   input  logic             GWEN,
   input  logic [31:0]      WEN,
   input  logic [IDX_W-1:0] A,
   input  logic [31:0]      D,
   output logic [31:0]      Q
);
   logic [31:0] mem_q [2**IDX_W];
   logic [31:0] q_q;

   // Q only moves on a read; writes and deselected cycles hold it.
   always_ff @(posedge CLK) begin
      if (!CEN) begin
         if (GWEN) begin
            q_q <= mem_q[A];
         end else begin
            mem_q[A] <= (mem_q[A] & WEN) | (D & ~WEN);
         end
      end
   end

   assign Q = q_q;
endmodule

module rf_16k (
   input  logic        CLK,
   input  logic        CEN,
   input  logic        GWEN,
   input  logic [31:0] WEN,
   input  logic [11:0] A,
   input  logic [31:0] D,
   input  logic [2:0]  EMA,
   input  logic [1:0]  EMAW,
   input  logic        RET1N,
   output logic [31:0] Q
);
   wire unused_ties = ^{EMA, EMAW, RET1N};

   sl_sram_rf_model #(.IDX_W(12)) u_model (
      .CLK(CLK), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
   );
endmodule

module rf_08k (
   input  logic        CLK,
   input  logic        CEN,
   input  logic        GWEN,
   input  logic [31:0] WEN,
   input  logic [10:0] A,
   input  logic [31:0] D,
   input  logic [2:0]  EMA,
   input  logic [1:0]  EMAW,
   input  logic        RET1N,
   output logic [31:0] Q
);
   wire unused_ties = ^{EMA, EMAW, RET1N};

   sl_sram_rf_model #(.IDX_W(11)) u_model (
      .CLK(CLK), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
   );
endmodule

`default_nettype wire

// File: rtl/sl_sram_banked.sv
// ----------------------------------------------------------------------------
// sl_sram_banked : NBANKS single-port macros tiled into one word-addressed RAM
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sl_sram_banked
   import sl_sram_pkg::*;
#(
   parameter int AW      = 16,
   parameter int BANK_AW = 14,
   parameter bit OUT_REG = 1'b0,
   parameter bit INIT_EN = 1'b1
) (
   input  logic            CLK,
   input  logic            RESETn,
   sl_sram_banked_if.slave bus
);
   localparam int NBANKS = 2**(AW-BANK_AW);
   localparam int IDX_W  = BANK_AW-2;
   localparam int BSEL_W = AW-BANK_AW;

   if (!bank_aw_legal(BANK_AW) || (AW <= BANK_AW)) begin : g_bad_cfg
      $error("sl_sram_banked: BANK_AW must be 13 or 14 and smaller than AW");
   end

   logic             clr_en;
   logic [IDX_W-1:0] clr_idx;
   logic             ready;

   if (INIT_EN) begin : g_init
      sl_sram_init_ctrl #(.IDX_W(IDX_W)) u_init_ctrl (
         .CLK        (CLK),
         .RESETn     (RESETn),
         .i_init_req (bus.INIT_REQ),
         .o_clr_en   (clr_en),
         .o_clr_idx  (clr_idx),
         .o_ready    (ready),
         .o_init_busy(bus.INIT_BUSY),
         .o_init_done(bus.INIT_DONE)
      );
   end else begin : g_no_init
      wire unused_init_req = bus.INIT_REQ;
      assign clr_en        = 1'b0;
      assign clr_idx       = '0;
      assign ready         = 1'b1;
      assign bus.INIT_BUSY = 1'b0;
      assign bus.INIT_DONE = 1'b0;
   end

   assign bus.READY = ready;

   logic [BSEL_W-1:0] w_bank;
   logic [IDX_W-1:0]  w_idx;
   logic              w_host_go;
   logic              w_rd_go;
   logic [31:0]       w_byte_en;
   logic [IDX_W-1:0]  w_mac_a;
   logic              w_mac_gwen;
   logic [31:0]       w_mac_wen;
   logic [31:0]       w_mac_d;
   logic [NBANKS-1:0] w_cen_n;
   logic [31:0]       w_q [NBANKS];

   assign w_bank    = bus.ADDR[AW-1:BANK_AW];
   assign w_idx     = bus.ADDR[BANK_AW-1:2];
   assign w_host_go = bus.CS & ready;
   assign w_rd_go   = w_host_go & ~|bus.WREN;
   assign w_byte_en = {{8{bus.WREN[3]}}, {8{bus.WREN[2]}}, {8{bus.WREN[1]}}, {8{bus.WREN[0]}}};

   // The clear engine owns every macro port while it runs.
   assign w_mac_a    = clr_en ? clr_idx : w_idx;
   assign w_mac_gwen = clr_en ? 1'b0    : ~|bus.WREN;
   assign w_mac_wen  = clr_en ? '0      : ~w_byte_en;
   assign w_mac_d    = clr_en ? '0      : bus.WDATA;

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      assign w_cen_n[b] = ~RESETn | ~(clr_en | (w_host_go & (w_bank == BSEL_W'(b))));

      if (BANK_AW == 14) begin : g_16k
         rf_16k u_macro (
            .CLK(CLK), .CEN(w_cen_n[b]), .GWEN(w_mac_gwen), .WEN(w_mac_wen),
            .A(w_mac_a), .D(w_mac_d), .EMA(c_macro_ema), .EMAW(c_macro_emaw),
            .RET1N(c_macro_ret1n), .Q(w_q[b])
         );
      end else begin : g_08k
         rf_08k u_macro (
            .CLK(CLK), .CEN(w_cen_n[b]), .GWEN(w_mac_gwen), .WEN(w_mac_wen),
            .A(w_mac_a), .D(w_mac_d), .EMA(c_macro_ema), .EMAW(c_macro_emaw),
            .RET1N(c_macro_ret1n), .Q(w_q[b])
         );
      end
   end

   logic [BSEL_W-1:0] sel_q, sel_d;
   logic              rd_pend_q, rd_pend_d;
   logic [31:0]       rdata_q, rdata_d;

   // Select only follows reads so RDATA keeps the last read value.
   always_comb begin
      sel_d     = sel_q;
      rd_pend_d = w_rd_go;
      rdata_d   = rdata_q;
      if (w_rd_go)   sel_d   = w_bank;
      if (rd_pend_q) rdata_d = w_q[sel_q];
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         sel_q     <= '0;
         rd_pend_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         sel_q     <= sel_d;
         rd_pend_q <= rd_pend_d;
         rdata_q   <= rdata_d;
      end
   end

   if (OUT_REG) begin : g_out_reg
      logic [31:0] out_q, out_d;
      assign out_d = rdata_q;
      always_ff @(posedge CLK or negedge RESETn) begin
         if (!RESETn) out_q <= '0;
         else         out_q <= out_d;
      end
      assign bus.RDATA = out_q;
   end else begin : g_no_out_reg
      assign bus.RDATA = rdata_q;
   end
endmodule

`default_nettype wire
